sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Bus-side controller that drives the single-port 1024x32 byte-masked SRAM wrapper.
- Accepts PicoRV32-style native memory requests (valid/ready, wstrb), issues registered SRAM commands and accounts for the 1-cycle SRAM read latency.
- Returns read data with a one-cycle ready pulse.
- After reset, optionally zero-fills the whole array before serving requests.
- Sits between the core/bus crossbar and the SRAM wrapper; one instance per SRAM bank.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width; depth = 2**ADDR_WIDTH words.
- INIT_EN, 1, 1 = sweep-write INIT_VALUE to every word after reset; 0 = skip.
- INIT_VALUE, 32'h0000_0000, word written during the init sweep.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- mem_valid_i  in  1  request valid.
- mem_ready_o  out  1  one-cycle completion pulse.
- mem_addr_i  in  32  byte address; word index = mem_addr_i[ADDR_WIDTH+1:2]; higher bits ignored, so the bank aliases.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; 0 = read, nonzero = write.
- mem_rdata_o  out  32  read data; valid while mem_ready_o is high after a read.
- init_done_o  out  1  high once the init sweep is finished; sticky until reset.
- sram_cs_o  out  1  SRAM chip select.
- sram_addr_o  out  ADDR_WIDTH  SRAM word address.
- sram_data_o  out  32  SRAM write data.
- sram_mask_o  out  4  SRAM byte write mask.
- sram_wren_o  out  1  SRAM write enable; 0 = read.
- sram_data_i  in  32  SRAM read data; valid the cycle after a read command is sampled.

Behaviour:
- Reset values: every output is 0 and the sweep counter is 0. Next state is INIT if INIT_EN=1, otherwise IDLE with init_done_o=1 from the first post-reset cycle.
- All SRAM command outputs and mem_ready_o/mem_rdata_o are registered; there are no combinational paths from bus inputs to outputs.
- States: INIT, IDLE, ACCESS, CAPTURE, RESP.
- INIT:
  - One write per cycle: cs=1, wren=1, mask=4'hF, data=INIT_VALUE, addr=counter; the counter increments each cycle.
  - After the cycle that issues addr=2**ADDR_WIDTH-1: init_done_o<=1, cs<=0, go to IDLE.
  - The sweep takes exactly 2**ADDR_WIDTH cycles of cs high.
  - mem_valid_i is ignored (ready stays low) during INIT. The request is held by the master and served afterwards.
- IDLE:
  - cs=0.
  - On mem_valid_i: register the command (cs=1, addr, and either wren=1/mask=wstrb/data=wdata, or wren=0/mask=0/data=0), then go to ACCESS.
- ACCESS:
  - The SRAM samples the command at the end of this cycle; cs<=0 next.
  - Write: mem_ready_o<=1, go to RESP. Read: go to CAPTURE.
- CAPTURE (read only): mem_rdata_o<=sram_data_i, mem_ready_o<=1, go to RESP.
- RESP: mem_ready_o is high for exactly this cycle. mem_ready_o<=0, go to IDLE.
- mem_rdata_o holds its last value otherwise; it is not cleared after a write.
- Latency, counting the cycle valid is first seen in IDLE as cycle 0: write ready in cycle 2, read ready in cycle 3. Back-to-back requests resume in the cycle after RESP, giving 3-cycle write and 4-cycle read throughput.
- The master deasserts mem_valid_i on the edge ending the ready cycle, so IDLE never re-accepts a completed request.
- If mem_valid_i drops mid-transaction (protocol violation), the transaction still completes and ready still pulses.
- Request inputs are sampled only in IDLE; changes in later states have no effect.
- Reset mid-operation (including mid-INIT): all outputs return to reset values, any in-flight access is abandoned (cs low next cycle), and INIT restarts from address 0.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the state enum (INIT, IDLE, ACCESS, CAPTURE, RESP);
  - constants WSTRB_READ=4'h0 and MASK_FULL=4'hF.
- No sub-module. The integration level instantiates sram_ctrl plus the SRAM wrapper; a behavioural SRAM model is used in simulation.

Test Plan:
- Reset with INIT_EN=1, ADDR_WIDTH=4 -> exactly 16 cycles of cs=1/wren=1/mask=F over addr 0..15, then init_done_o=1; a mem_valid_i held from reset stays unready until after init_done_o rises.
- Write addr 0x0000_0010, wdata 0xDEADBEEF, wstrb F, then read addr 0x10 -> write ready in cycle 2; SRAM word 4 = 0xDEADBEEF; read ready in cycle 3 with rdata 0xDEADBEEF.
- Byte-masked write wstrb 4'b0101 with wdata 0x11223344 over 0xAAAAAAAA -> readback 0xAA22AA44; sram_mask_o=4'b0101 during the write command.
- Alias check, ADDR_WIDTH=10: write 0x0000_1004 then read 0x0000_0004 -> same word returned; last address 0xFFC reads/writes word 1023 without wrap error.
- Reset asserted mid-INIT at counter 7 and mid-read in ACCESS -> next cycle all outputs 0 and the sweep restarts at addr 0; no ready pulse is emitted.
- mem_valid_i dropped during ACCESS of a read -> ready still pulses exactly once in cycle 3; a new request issued the cycle after RESP is accepted.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the bus-to-SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] MASK_FULL  = 4'hF;

endpackage

// File: rtl/sram_ctrl.sv
// Native valid/ready memory port to single-port byte-masked SRAM controller,
// with an optional post-reset fill sweep. Every output is registered.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [3:0]            mem_wstrb_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  init_done_o,
  output logic                  sram_cs_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_data_o,
  output logic [3:0]            sram_mask_o,
  output logic                  sram_wren_o,
  input  logic [31:0]           sram_data_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  wren_q, wren_d;
  logic [3:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  done_q, done_d;

  // Address bits outside the bank are deliberately ignored so the bank aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    wren_d  = wren_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    done_d  = done_q | ~INIT_EN;

    case (state_q)
      ST_INIT: begin
        // The last sweep write is already on the outputs: stop here.
        if (cs_q && addr_q == LAST_ADDR) begin
          cs_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cs_d   = 1'b1;
          wren_d = 1'b1;
          mask_d = MASK_FULL;
          data_d = INIT_VALUE;
          addr_d = cnt_q;
          cnt_d  = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        cs_d = 1'b0;
        if (mem_valid_i) begin
          cs_d    = 1'b1;
          addr_d  = mem_addr_i[ADDR_WIDTH+1:2];
          state_d = ST_ACCESS;
          if (mem_wstrb_i != WSTRB_READ) begin
            wren_d = 1'b1;
            mask_d = mem_wstrb_i;
            data_d = mem_wdata_i;
          end else begin
            wren_d = 1'b0;
            mask_d = 4'h0;
            data_d = 32'h0;
          end
        end
      end
      ST_ACCESS: begin
        cs_d = 1'b0;
        if (wren_q) begin
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_d = sram_data_i;
        ready_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      wren_q  <= 1'b0;
      mask_q  <= 4'h0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      wren_q  <= wren_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign init_done_o = done_q;
  assign sram_cs_o   = cs_q;
  assign sram_addr_o = addr_q;
  assign sram_data_o = data_q;
  assign sram_mask_o = mask_q;
  assign sram_wren_o = wren_q;

endmodule
